mem_port_arbiter: RTL and testbench

//   Shares one single-port unified memory between instruction fetch (IF) and the

---
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF and DM.
// Optional IF starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [2:0]    dm_op,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [2:0]    mem_op,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);
    localparam logic [2:0] OP_WORD  = 3'b010;

    if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT must be 1..7, STARVE_MAX >= 1");
    end

    state_t        state_q;
    state_t        state_d;
    logic [2:0]    lat_q;
    logic [2:0]    lat_d;
    logic          own_dm_q;
    logic          own_dm_d;
    logic          own_we_q;
    logic          own_we_d;
    logic          pick_if;

    logic          if_gnt_d;
    logic          dm_gnt_d;
    logic          if_rvalid_d;
    logic          dm_rvalid_d;
    logic          mem_en_d;
    logic          mem_we_d;
    logic [2:0]    mem_op_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;

    logic [DW-1:0] if_hold_q;
    logic [DW-1:0] dm_hold_q;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;

    // IF wins outright once it has lost STARVE_MAX arbitrations in a row
    always_comb begin
        pick_if  = if_req && (!dm_req || starve_q == S_MAX);
        starve_d = starve_q;
        if (state_q == IDLE && if_req) begin
            if (pick_if) begin
                starve_d = '0;
            end else if (starve_q != S_MAX) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // consecutive-loss counter for IF
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // strict DM-over-IF priority
    always_comb pick_if = if_req && !dm_req;
`endif

    // next state and next values of every registered output
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        own_dm_d    = own_dm_q;
        own_we_d    = own_we_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_op_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    own_dm_d = !pick_if;
                    mem_en_d = 1'b1;
                    lat_d    = LAT_LOAD;
                    state_d  = (MEM_LAT == 1) ? RESP : WAIT;
                    if (pick_if) begin
                        if_gnt_d   = 1'b1;
                        own_we_d   = 1'b0;
                        mem_op_d   = OP_WORD;
                        mem_addr_d = if_addr;
                    end else begin
                        dm_gnt_d    = 1'b1;
                        own_we_d    = dm_we;
                        mem_we_d    = dm_we;
                        mem_op_d    = dm_op;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end
                end
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if_rvalid_d = !own_dm_q;
                dm_rvalid_d = own_dm_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, owner and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            own_dm_q  <= 1'b0;
            own_we_q  <= 1'b0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_op    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            own_dm_q  <= own_dm_d;
            own_we_q  <= own_we_d;
            if_gnt    <= if_gnt_d;
            dm_gnt    <= dm_gnt_d;
            if_rvalid <= if_rvalid_d;
            dm_rvalid <= dm_rvalid_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_op    <= mem_op_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // keep the last response so rdata holds between rvalid pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            if_hold_q <= '0;
            dm_hold_q <= '0;
        end else begin
            if (if_rvalid) begin
                if_hold_q <= mem_rdata;
            end
            if (dm_rvalid) begin
                dm_hold_q <= own_we_q ? '0 : mem_rdata;
            end
        end
    end

    // memory data arrives in the rvalid cycle itself, so it is forwarded
    assign if_rdata = if_rvalid ? mem_rdata : if_hold_q;
    assign dm_rdata = dm_rvalid ? (own_we_q ? '0 : mem_rdata) : dm_hold_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random + directed bench with a transaction-level
// model of the arbiter; a second instance covers MEM_LAT=1 streaming.
module tb_mem_port_arbiter;

    localparam int L    = 2;
    localparam int SMAX = 3;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [2:0]  dm_op;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_en, mem_we, busy;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(L), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_op(dm_op),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // second instance: MEM_LAT=1, IF only
    logic        reset1, if_req1, if_gnt1, if_rvalid1;
    logic [31:0] if_addr1, if_rdata1, dm_rdata1;
    logic        dm_gnt1, dm_rvalid1, mem_en1, mem_we1, busy1;
    logic [2:0]  mem_op1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

    mem_port_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(SMAX)
    ) dut1 (
        .clk(clk), .reset(reset1),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .dm_req(1'b0), .dm_we(1'b0), .dm_op(3'b000),
        .dm_addr(32'h0), .dm_wdata(32'h0), .dm_gnt(dm_gnt1),
        .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_op(mem_op1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic chk_str(input string nm, input string act,
                           input string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%s required=%s", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input logic [31:0] old,
                                       input logic [2:0] op,
                                       input logic [1:0] a,
                                       input logic [31:0] d);
        logic [31:0] r;
        int b;
        r = old;
        b = int'(a);
        case (op[1:0])
            2'b00:   r[b*8 +: 8] = d[7:0];
            2'b01:   r[(b/2)*16 +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    // environment RAM: word array, read data valid L cycles after mem_en
    logic [31:0] ram [256];
    logic [31:0] rpipe [L];
    bit          vpipe [L];
    logic [31:0] noise;

    always @(posedge clk) begin
        noise <= $urandom;
        if (mem_en && mem_we)
            ram[mem_addr[9:2]] <= st(ram[mem_addr[9:2]], mem_op,
                                     mem_addr[1:0], mem_wdata);
        vpipe[0] <= mem_en && !mem_we;
        rpipe[0] <= ram[mem_addr[9:2]];
        for (int i = 1; i < L; i++) begin
            vpipe[i] <= vpipe[i-1];
            rpipe[i] <= rpipe[i-1];
        end
        mem_rdata1 <= mem_en1 ? {16'hBEEF, mem_addr1[15:0]} : $urandom;
    end
    assign mem_rdata = vpipe[L-1] ? rpipe[L-1] : noise;

    // transaction-level reference model
    logic [31:0] shadow [256];
    bit          act = 1'b0;
    int          g = 0;
    int          starve = 0;
    bit          own_dm, pick_if, idle_prev;
    logic [31:0] own_word;
    bit          e_ignt, e_dgnt, e_en, e_we, e_irv, e_drv, e_busy;
    logic [2:0]  e_op;
    logic [31:0] e_addr, e_wd;
    logic [31:0] e_irdh = 32'h0;
    logic [31:0] e_drdh = 32'h0;

    always @(posedge clk) begin
        cyc++;
        e_ignt = 0; e_dgnt = 0; e_en = 0; e_we = 0;
        e_irv = 0; e_drv = 0; e_op = 0; e_addr = 0; e_wd = 0;
        if (reset) begin
            act = 0; starve = 0; e_busy = 0;
            e_irdh = 0; e_drdh = 0;
        end else begin
            idle_prev = !act || (cyc - 1 >= g + L);
            if (act && cyc == g + L) begin
                if (own_dm) begin
                    e_drv = 1; e_drdh = own_word;
                end else begin
                    e_irv = 1; e_irdh = own_word;
                end
            end
            if (idle_prev && (if_req || dm_req)) begin
                pick_if = if_req &&
                          (!dm_req || (GUARD && starve == SMAX));
                if (pick_if) starve = 0;
                else if (if_req && starve < SMAX) starve++;
                g = cyc; act = 1; own_dm = !pick_if; e_en = 1;
                if (pick_if) begin
                    e_ignt = 1; e_op = 3'b010; e_addr = if_addr;
                    own_word = shadow[if_addr[9:2]];
                end else begin
                    e_dgnt = 1; e_we = dm_we; e_op = dm_op;
                    e_addr = dm_addr; e_wd = dm_wdata;
                    if (dm_we) begin
                        shadow[dm_addr[9:2]] = st(shadow[dm_addr[9:2]],
                            dm_op, dm_addr[1:0], dm_wdata);
                        own_word = 0;
                    end else begin
                        own_word = shadow[dm_addr[9:2]];
                    end
                end
            end
            e_busy = act && cyc >= g && cyc < g + L;
        end
    end

    // compare every output against the model each cycle
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("if_gnt", if_gnt, e_ignt);
            chk("dm_gnt", dm_gnt, e_dgnt);
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            chk("mem_op", mem_op, e_op);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
            chk("if_rvalid", if_rvalid, e_irv);
            chk("dm_rvalid", dm_rvalid, e_drv);
            chk("if_rdata", if_rdata, e_irdh);
            chk("dm_rdata", dm_rdata, e_drdh);
            chk("busy", busy, e_busy);
        end
    end

    // MEM_LAT=1 streaming checks
    int last_g1 = -1;
    int n_gnt1  = 0;
    always @(negedge clk) begin
        if (cyc >= 1 && !reset1) begin
            if (if_gnt1) begin
                if (last_g1 >= 0) chk("t6_gnt_gap", cyc - last_g1, 2);
                chk("t6_mem_op", {mem_en1, mem_op1}, 4'b1010);
                last_g1 = cyc;
                n_gnt1++;
            end
            if (if_rvalid1) begin
                chk("t6_rv_lat", cyc - last_g1, 1);
                chk("t6_rdata", if_rdata1,
                    {16'hBEEF, 16'(if_addr1 - 32'd4)});
            end
            chk("t6_dm_quiet", {dm_gnt1, dm_rvalid1, mem_we1,
                |mem_wdata1, |dm_rdata1}, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ev(input int which, output int c);
        c = -100;
        for (int i = 0; i < 16; i++) begin
            step();
            if ((which == 0 && if_gnt) || (which == 1 && if_rvalid) ||
                (which == 2 && dm_gnt) || (which == 3 && dm_rvalid)) begin
                c = cyc;
                break;
            end
        end
    endtask

    initial begin
        reset1 = 1; if_req1 = 0; if_addr1 = 0;
        repeat (2) step();
        reset1 = 0; if_req1 = 1;
        forever begin
            step();
            if (if_gnt1) if_addr1 += 4;
        end
    end

    int    c0, c, r, sawrv;
    string seq;
    bit    stop_new;

    initial begin
        reset = 1; if_req = 0; dm_req = 0; dm_we = 0; dm_op = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'hC0DE0000 | (i << 2);
            shadow[i] = 32'hC0DE0000 | (i << 2);
        end
        repeat (3) step();
        reset = 0;
        step();

        // solo IF fetch
        if_req = 1; if_addr = 32'h40; c0 = cyc;
        wait_ev(0, c); if_req = 0;
        chk("t1_gnt_cycle", c - c0, 1);
        wait_ev(1, r);
        chk("t1_rv_lat", r - c, 2);
        chk("t1_rdata", if_rdata, 32'hC0DE0040);

        // collision: DM first, IF right after
        step();
        if_req = 1; if_addr = 32'h80;
        dm_req = 1; dm_we = 0; dm_op = 3'b010; dm_addr = 32'h100;
        wait_ev(2, c); dm_req = 0;
        chk("t2_no_if_gnt", if_gnt, 0);
        wait_ev(3, r);
        chk("t2_dm_lat", r - c, 2);
        chk("t2_dm_rdata", dm_rdata, 32'hC0DE0100);
        wait_ev(0, c); if_req = 0;
        chk("t2_if_after", c - r, 1);
        wait_ev(1, r);
        chk("t2_if_rdata", if_rdata, 32'hC0DE0080);

        // byte store
        step();
        dm_req = 1; dm_we = 1; dm_op = 3'b000;
        dm_addr = 32'h103; dm_wdata = 32'hAB;
        wait_ev(2, c); dm_req = 0; dm_we = 0;
        chk("t3_mem_we", mem_we, 1);
        chk("t3_mem_op", mem_op, 0);
        chk("t3_mem_addr", mem_addr, 32'h103);
        wait_ev(3, r);
        chk("t3_rdata0", dm_rdata, 0);
        step();
        chk("t3_ram_byte", ram[64][31:24], 8'hAB);

        // both held: grant order
        dm_req = 1; dm_we = 0; dm_op = 3'b010; dm_addr = 32'h200;
        if_req = 1; if_addr = 32'h300;
        seq = "";
        for (int i = 0; i < 40 && seq.len() < 8; i++) begin
            step();
            if (dm_gnt) seq = {seq, "D"};
            if (if_gnt) seq = {seq, "I"};
        end
        chk_str("t4_order", seq, GUARD ? "DDDIDDDI" : "DDDDDDDD");
        if (if_gnt) begin
            if_req = 0; wait_ev(2, c); dm_req = 0;
        end else begin
            dm_req = 0; wait_ev(0, c); if_req = 0;
        end
        repeat (4) step();

        // reset during WAIT of a load
        dm_req = 1; dm_we = 0; dm_op = 3'b010; dm_addr = 32'h200;
        wait_ev(2, c); dm_req = 0;
        reset = 1;
        step();
        reset = 0;
        chk("t5_busy", busy, 0);
        sawrv = 0;
        repeat (4) begin
            step();
            if (dm_rvalid) sawrv++;
        end
        chk("t5_no_rvalid", sawrv, 0);
        if_req = 1; if_addr = 32'h44; c0 = cyc;
        wait_ev(0, c); if_req = 0;
        chk("t5_regnt", c - c0, 1);
        wait_ev(1, r);
        chk("t5_rdata", if_rdata, 32'hC0DE0044);

        // random traffic
        stop_new = 0;
        for (int i = 0; i < 900; i++) begin
            step();
            if (i >= 880) stop_new = 1;
            if (if_gnt) if_req = 0;
            if (dm_gnt) dm_req = 0;
            if (!stop_new && !if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1;
                if_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!stop_new && !dm_req && $urandom_range(0, 2) == 0) begin
                dm_req   = 1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_wdata = $urandom;
                dm_addr  = 32'($urandom_range(0, 1023));
                case ($urandom_range(0, 4))
                    0: dm_op = 3'b000;
                    1: dm_op = 3'b001;
                    2: dm_op = 3'b010;
                    3: dm_op = dm_we ? 3'b000 : 3'b100;
                    default: dm_op = dm_we ? 3'b001 : 3'b101;
                endcase
                if (dm_op[1:0] == 2'b01) dm_addr[0] = 1'b0;
                if (dm_op[1:0] == 2'b10) dm_addr[1:0] = 2'b00;
            end
        end
        repeat (6) step();

        chk("t6_gnt_count", n_gnt1 >= 10, 1);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
